seq_magnitude_comparator: RTL and testbench

Parametrised multi-cycle magnitude comparator. It generalises the 4-bit eq/lt/gt comparator to WIDTH-bit operands, signed or unsigned. Operands are compared SLICE bits per cycle, MSB slice first, behind a valid/ready handshake on both input and output. It is the building block for wide compare paths, such as 8/16/32-bit, where a single flat comparator is too slow.

---
 rtl/seq_magnitude_comparator_if.sv | 25 ++
 rtl/seq_magnitude_comparator.sv | 163 ++++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_magnitude_comparator_if.sv
// rtl/seq_magnitude_comparator_if.sv - Operand/result handshake bundle for seq_magnitude_comparator
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             lt;
    logic             gt;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, eq, lt, gt
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, eq, lt, gt
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - Multi-cycle sliced eq/lt/gt comparator, MSB slice first (option macro: CMP_EARLY_EXIT_EN)
module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seq_magnitude_comparator_if.slave   bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
`ifndef CMP_EARLY_EXIT_EN
    // Sticky decision from the most significant differing slice; kept apart
    // from eq/lt/gt so the outputs stay zero until the walk completes.
    logic             decided_q, decided_d;
    logic             dlt_q, dlt_d;
    logic             dgt_q, dgt_d;
`endif
    logic [SLICE-1:0] sa, sb;
    logic             accept;

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.eq        = eq_q;
    assign bus.lt        = lt_q;
    assign bus.gt        = gt_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Current slice pair; the top slice's MSB is flipped for signed compares
    // so an unsigned compare of the slices orders two's-complement values.
    always_comb begin
        sa = a_q[int'(idx_q) * SLICE +: SLICE];
        sb = b_q[int'(idx_q) * SLICE +: SLICE];
        if (signed_q && (idx_q == TOP_IDX)) begin
            sa[SLICE-1] = ~sa[SLICE-1];
            sb[SLICE-1] = ~sb[SLICE-1];
        end
    end

    // Next-state and datapath update for IDLE/CMP/DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        gt_d     = gt_q;
`ifndef CMP_EARLY_EXIT_EN
        decided_d = decided_q;
        dlt_d     = dlt_q;
        dgt_d     = dgt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    signed_d = bus.signed_mode;
                    idx_d    = TOP_IDX;
`ifndef CMP_EARLY_EXIT_EN
                    decided_d = 1'b0;
                    dlt_d     = 1'b0;
                    dgt_d     = 1'b0;
`endif
                    state_d  = CMP;
                end
            end
            CMP: begin
`ifdef CMP_EARLY_EXIT_EN
                if (sa != sb) begin
                    gt_d    = (sa > sb);
                    lt_d    = (sa < sb);
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
`else
                if (!decided_q && (sa != sb)) begin
                    decided_d = 1'b1;
                    dlt_d     = (sa < sb);
                    dgt_d     = (sa > sb);
                end
                if (idx_q == '0) begin
                    eq_d    = !decided_d;
                    lt_d    = dlt_d;
                    gt_d    = dgt_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any compare in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            decided_q <= 1'b0;
            dlt_q     <= 1'b0;
            dgt_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            gt_q     <= gt_d;
`ifndef CMP_EARLY_EXIT_EN
            decided_q <= decided_d;
            dlt_q     <= dlt_d;
            dgt_q     <= dgt_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - Randomised self-checking bench for seq_magnitude_comparator
module tb_seq_magnitude_comparator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    seq_magnitude_comparator_if #(.WIDTH(8))  if8 ();
    seq_magnitude_comparator_if #(.WIDTH(16)) if16 ();
    seq_magnitude_comparator_if #(.WIDTH(32)) if32 ();

    seq_magnitude_comparator #(.WIDTH(8),  .SLICE(4)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    seq_magnitude_comparator #(.WIDTH(16), .SLICE(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    seq_magnitude_comparator #(.WIDTH(32), .SLICE(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input int sel);
        case (sel)
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int slc(input int sel);
        return (sel == 2) ? 8 : 4;
    endfunction

    function automatic logic [31:0] wmask(input int w);
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        return m[31:0];
    endfunction

    // Reference: compare the operands as plain integers.
    function automatic logic [2:0] ref_cmp(input logic [31:0] va, input logic [31:0] vb,
                                           input logic sm, input int w);
        longint x, y;
        x = longint'(va);
        y = longint'(vb);
        if (sm && va[w-1]) x = x - (longint'(1) << w);
        if (sm && vb[w-1]) y = y - (longint'(1) << w);
        return {x == y, x < y, x > y};
    endfunction

    // Reference latency: slices walked until the first difference, MSB first.
    function automatic int ref_lat(input logic [31:0] va, input logic [31:0] vb,
                                   input int w, input int s);
        int n;
        int first;
        n = w / s;
        first = n;
        for (int k = 0; k < n; k++) begin
            if (((((va ^ vb) >> ((n - 1 - k) * s)) & wmask(s)) != 0) && (first == n)) first = k + 1;
        end
`ifdef CMP_EARLY_EXIT_EN
        return first;
`else
        return (first > 0) ? n : 0;
`endif
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [31:0] va,
                          input logic [31:0] vb, input logic sm);
        case (sel)
            0: begin if8.in_valid = v;  if8.a = va[7:0];   if8.b = vb[7:0];   if8.signed_mode = sm;  end
            1: begin if16.in_valid = v; if16.a = va[15:0]; if16.b = vb[15:0]; if16.signed_mode = sm; end
            default: begin if32.in_valid = v; if32.a = va; if32.b = vb; if32.signed_mode = sm; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic r);
        case (sel)
            0:       if8.out_ready = r;
            1:       if16.out_ready = r;
            default: if32.out_ready = r;
        endcase
    endtask

    // {in_ready, out_valid, eq, lt, gt}
    task automatic get_out(input int sel, output logic [4:0] o);
        case (sel)
            0:       o = {if8.in_ready, if8.out_valid, if8.eq, if8.lt, if8.gt};
            1:       o = {if16.in_ready, if16.out_valid, if16.eq, if16.lt, if16.gt};
            default: o = {if32.in_ready, if32.out_valid, if32.eq, if32.lt, if32.gt};
        endcase
    endtask

    task automatic do_cmp(input int sel, input logic [31:0] a_in, input logic [31:0] b_in,
                          input logic sm, input int hold);
        logic [4:0]  o;
        logic [2:0]  e;
        logic [31:0] va, vb;
        int lat, cyc;
        bit ok;
        va  = a_in & wmask(wid(sel));
        vb  = b_in & wmask(wid(sel));
        e   = ref_cmp(va, vb, sm, wid(sel));
        lat = ref_lat(va, vb, wid(sel), slc(sel));
        set_ordy(sel, hold == 0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            get_out(sel, o);
            if (o[4]) begin ok = 1; break; end
            @(posedge clk); @(negedge clk);
        end
        if (!ok) begin check("in_ready_timeout", 32'd0, 32'd1); return; end
        set_in(sel, 1'b1, va, vb, sm);
        @(posedge clk); @(negedge clk);
        set_in(sel, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc = 0;
        ok = 0;
        while (cyc < 64) begin
            get_out(sel, o);
            if (o[3]) begin ok = 1; break; end
            check("busy_quiet", 32'(o), 32'd0);
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        if (!ok) begin check("result_timeout", 32'd0, 32'd1); return; end
        check("latency", 32'(cyc), 32'(lat));
        check("result", 32'(o), 32'({2'b01, e}));
        for (int h = 0; h < hold; h++) begin
            set_in(sel, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            @(posedge clk); @(negedge clk);
            get_out(sel, o);
            check("held", 32'(o), 32'({2'b01, e}));
        end
        set_in(sel, 1'b0, 32'd0, 32'd0, 1'b0);
        set_ordy(sel, 1'b1);
        @(posedge clk); @(negedge clk);
        get_out(sel, o);
        check("drained", 32'(o), 32'h10);
    endtask

    initial begin
        logic [4:0]  o;
        logic [31:0] ra, rb;
        for (int s = 0; s < 3; s++) begin
            set_in(s, 1'b0, 32'd0, 32'd0, 1'b0);
            set_ordy(s, 1'b1);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            get_out(s, o);
            check("reset_state", 32'(o), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            get_out(s, o);
            check("idle_ready", 32'(o), 32'h10);
        end

        do_cmp(0, 32'h3C, 32'h3C, 1'b0, 0);
        do_cmp(0, 32'h50, 32'h4F, 1'b0, 0);
        do_cmp(0, 32'h80, 32'h7F, 1'b1, 0);
        do_cmp(0, 32'h80, 32'h7F, 1'b0, 0);
        do_cmp(0, 32'hFF, 32'hFE, 1'b1, 0);
        do_cmp(0, 32'h50, 32'h4F, 1'b0, 5);
        do_cmp(0, 32'h3C, 32'h3C, 1'b1, 5);

        // Reset during the second CMP cycle of a 16-bit compare.
        set_ordy(1, 1'b1);
        set_in(1, 1'b1, 32'h1234, 32'h1234, 1'b0);
        @(posedge clk); @(negedge clk);
        set_in(1, 1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        get_out(1, o);
        check("rst_mid_cmp", 32'(o), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            get_out(1, o);
            check("no_stale", 32'(o), 32'h10);
        end
        do_cmp(1, 32'h1234, 32'h1234, 1'b0, 0);

        do_cmp(2, 32'h12345678, 32'h12345679, 1'b0, 0);
        do_cmp(2, 32'h12345678, 32'h12345679, 1'b0, 0);
        do_cmp(2, 32'h80000000, 32'h7FFFFFFF, 1'b1, 0);

        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < 40; n++) begin
                ra = $urandom;
                case ($urandom_range(0, 3))
                    0:       rb = ra;
                    1:       rb = ra ^ (32'd1 << $urandom_range(0, wid(s) - 1));
                    default: rb = $urandom;
                endcase
                do_cmp(s, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
